pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// PC sequencer: issues a PC to the cpu, holds it for HOLD_CYCLES, then steps or branches.
// Optional branch-to-self halt detection is enabled by defining PC_SEQ_LOOP_DET_EN.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [15:0] PC_MAX      = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic [15:0] cpu_pc_next,
  input  logic        cpu_pc_next_vld,
  output logic [15:0] pc,
  output logic        pc_vld,
  output logic        busy,
  output logic        halted,
  output logic [15:0] issue_count
);

  localparam int unsigned PC_W  = 16;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [PC_W-1:0]  CNT_SAT   = {PC_W{1'b1}};

  logic [1:0]       state, state_d;
  logic [PC_W-1:0]  pc_d;
  logic [PC_W-1:0]  issue_count_d;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
  logic             pc_vld_d, busy_d, halted_d;

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_vld      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      issue_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      pc_vld      <= pc_vld_d;
      busy        <= busy_d;
      halted      <= halted_d;
      issue_count <= issue_count_d;
      wait_cnt    <= wait_cnt_d;
    end
  end

  // Next-state and next-output logic; flags are decoded from the next state so they align with pc
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    issue_count_d = issue_count;
    wait_cnt_d    = wait_cnt;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          pc_d    = RESET_PC;
        end
      end

      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = HOLD_LOAD;
        if (issue_count != CNT_SAT) begin
          issue_count_d = issue_count + PC_W'(1);
        end
      end

      WAIT: begin
        if (!stall) begin
          if (wait_cnt <= CNT_W'(1)) begin
            wait_cnt_d = '0;
            if (cpu_pc_next_vld) begin
`ifdef PC_SEQ_LOOP_DET_EN
              if (cpu_pc_next == pc) begin
                state_d = HALT;
              end else begin
                state_d = ISSUE;
                pc_d    = cpu_pc_next;
              end
`else
              state_d = ISSUE;
              pc_d    = cpu_pc_next;
`endif
            end else if (pc == PC_MAX) begin
              state_d = HALT;
            end else begin
              state_d = ISSUE;
              pc_d    = pc + PC_W'(1);
            end
          end else begin
            wait_cnt_d = wait_cnt - CNT_W'(1);
          end
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    pc_vld_d = (state_d == ISSUE);
    busy_d   = (state_d == ISSUE) || (state_d == WAIT);
    halted_d = (state_d == HALT);
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table on a default instance plus a short-PC_MAX instance.
module tb_pc_sequencer;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        stall;
    logic        nxt_vld;
    logic [15:0] nxt;
    logic [15:0] e_pc;
    logic        e_vld;
    logic        e_busy;
    logic        e_halt;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, start = 1'b0, stall = 1'b0, nxt_vld = 1'b0;
  logic [15:0] nxt = '0;
  logic [15:0] pc, issue_count;
  logic        pc_vld, busy, halted;

  logic        rst2_n = 1'b0, start2 = 1'b0, stall2 = 1'b0, nxt_vld2 = 1'b0;
  logic [15:0] nxt2 = '0;
  logic [15:0] pc2, issue_count2;
  logic        pc_vld2, busy2, halted2;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .cpu_pc_next(nxt), .cpu_pc_next_vld(nxt_vld),
    .pc(pc), .pc_vld(pc_vld), .busy(busy), .halted(halted),
    .issue_count(issue_count)
  );

  pc_sequencer #(.RESET_PC(16'h0000), .HOLD_CYCLES(1), .PC_MAX(16'h0003)) dut_short (
    .clk(clk), .rst_n(rst2_n), .start(start2), .stall(stall2),
    .cpu_pc_next(nxt2), .cpu_pc_next_vld(nxt_vld2),
    .pc(pc2), .pc_vld(pc_vld2), .busy(busy2), .halted(halted2),
    .issue_count(issue_count2)
  );

  function automatic void add(input logic r, input logic s, input logic st,
                              input logic nv, input logic [15:0] n,
                              input logic [15:0] epc, input logic ev,
                              input logic eb, input logic eh, input logic [15:0] ec);
    vec_t v;
    v.rst_n = r; v.start = s; v.stall = st; v.nxt_vld = nv; v.nxt = n;
    v.e_pc = epc; v.e_vld = ev; v.e_busy = eb; v.e_halt = eh; v.e_cnt = ec;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step2(input logic r, input logic s, input logic nv, input logic [15:0] n);
    @(negedge clk);
    rst2_n = r; start2 = s; nxt_vld2 = nv; nxt2 = n; stall2 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst_n start stall nxt_vld nxt | pc vld busy halt count
    add(0,0,0,0,16'd0,   16'd0, 0,0,0,16'd0);
    add(1,0,0,0,16'd0,   16'd0, 0,0,0,16'd0);
    add(1,0,1,1,16'd7,   16'd0, 0,0,0,16'd0);
    add(1,1,0,0,16'd0,   16'd0, 1,1,0,16'd0);
    add(1,0,0,0,16'd0,   16'd0, 0,1,0,16'd1);
    add(1,0,0,0,16'd0,   16'd0, 0,1,0,16'd1);
    add(1,0,0,0,16'd0,   16'd1, 1,1,0,16'd1);
    add(1,1,0,0,16'd0,   16'd1, 0,1,0,16'd2);
    for (int i = 0; i < 4; i++) add(1,0,1,0,16'd0, 16'd1, 0,1,0,16'd2);
    add(1,0,0,0,16'd0,   16'd1, 0,1,0,16'd2);
    add(1,0,0,0,16'd0,   16'd2, 1,1,0,16'd2);
    add(1,0,0,0,16'd0,   16'd2, 0,1,0,16'd3);
    add(1,0,0,0,16'd0,   16'd2, 0,1,0,16'd3);
    add(1,0,1,1,16'd14,  16'd2, 0,1,0,16'd3);
    add(1,0,0,1,16'd14,  16'd14,1,1,0,16'd3);
    add(1,0,0,1,16'h55,  16'd14,0,1,0,16'd4);
    add(1,0,0,0,16'd0,   16'd14,0,1,0,16'd4);
    add(1,0,0,1,16'd6,   16'd6, 1,1,0,16'd4);
    add(1,0,0,0,16'd0,   16'd6, 0,1,0,16'd5);
    add(1,0,0,0,16'd0,   16'd6, 0,1,0,16'd5);
    add(1,0,0,1,16'd10,  16'd10,1,1,0,16'd5);
    add(1,0,0,0,16'd0,   16'd10,0,1,0,16'd6);
    add(1,0,0,0,16'd0,   16'd10,0,1,0,16'd6);
`ifdef PC_SEQ_LOOP_DET_EN
    add(1,0,0,1,16'd10,  16'd10,0,0,1,16'd6);
    add(1,1,0,0,16'd0,   16'd10,0,0,1,16'd6);
    add(1,0,0,0,16'd0,   16'd10,0,0,1,16'd6);
`else
    add(1,0,0,1,16'd10,  16'd10,1,1,0,16'd6);
    add(1,0,0,0,16'd0,   16'd10,0,1,0,16'd7);
    add(1,0,0,0,16'd0,   16'd10,0,1,0,16'd7);
    add(1,0,0,1,16'd10,  16'd10,1,1,0,16'd7);
    add(1,0,0,0,16'd0,   16'd10,0,1,0,16'd8);
    add(1,0,0,0,16'd0,   16'd10,0,1,0,16'd8);
    add(1,0,0,1,16'd5,   16'd5, 1,1,0,16'd8);
    add(1,0,0,0,16'd0,   16'd5, 0,1,0,16'd9);
`endif
    add(0,0,0,0,16'd0,   16'd0, 0,0,0,16'd0);
    add(1,0,0,1,16'd3,   16'd0, 0,0,0,16'd0);
    add(1,0,0,0,16'd0,   16'd0, 0,0,0,16'd0);
    add(1,1,0,0,16'd0,   16'd0, 1,1,0,16'd0);
    add(0,0,0,0,16'd0,   16'd0, 0,0,0,16'd0);
    add(1,0,0,0,16'd0,   16'd0, 0,0,0,16'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; start = vecs[i].start; stall = vecs[i].stall;
      nxt_vld = vecs[i].nxt_vld; nxt = vecs[i].nxt;
      @(posedge clk);
      #1;
      chk("pc", i, pc, vecs[i].e_pc);
      chk("pc_vld", i, 16'(pc_vld), 16'(vecs[i].e_vld));
      chk("busy", i, 16'(busy), 16'(vecs[i].e_busy));
      chk("halted", i, 16'(halted), 16'(vecs[i].e_halt));
      chk("issue_count", i, issue_count, vecs[i].e_cnt);
    end

    // Short instance: HOLD_CYCLES=1, PC_MAX=3; branch out of PC_MAX once, then run into halt
    step2(1'b0, 1'b0, 1'b0, 16'd0);
    chk("s_reset_halted", 0, 16'(halted2), 16'd0);
    chk("s_reset_count", 0, issue_count2, 16'd0);
    step2(1'b1, 1'b1, 1'b0, 16'd0);
    for (int k = 0; k < 8; k++) begin
      chk("s_issue_vld", k, 16'(pc_vld2), 16'd1);
      chk("s_issue_pc", k, pc2, 16'(k % 4));
      step2(1'b1, 1'b0, 1'b0, 16'd0);
      chk("s_wait_vld", k, 16'(pc_vld2), 16'd0);
      chk("s_wait_busy", k, 16'(busy2), 16'd1);
      chk("s_wait_pc", k, pc2, 16'(k % 4));
      step2(1'b1, 1'b0, (k == 3), 16'd0);
    end
    chk("s_halt_halted", 0, 16'(halted2), 16'd1);
    chk("s_halt_busy", 0, 16'(busy2), 16'd0);
    chk("s_halt_vld", 0, 16'(pc_vld2), 16'd0);
    chk("s_halt_pc", 0, pc2, 16'd3);
    chk("s_halt_count", 0, issue_count2, 16'd8);
    step2(1'b1, 1'b1, 1'b0, 16'd0);
    step2(1'b1, 1'b0, 1'b0, 16'd0);
    chk("s_start_ign_halted", 0, 16'(halted2), 16'd1);
    chk("s_start_ign_vld", 0, 16'(pc_vld2), 16'd0);
    chk("s_start_ign_pc", 0, pc2, 16'd3);
    chk("s_start_ign_count", 0, issue_count2, 16'd8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
